// File: rtl/dmx512_transmitter_pkg.sv
// Shared constants, state encoding and default timing
// for the DMX512 transmitter.
package dmx512_transmitter_pkg;

    localparam logic [7:0] DMX_START_CODE = 8'h00;
    localparam int DMX_SLOT_BITS = 11;

    localparam int DMX_CLKS_PER_BIT = 260;
    localparam int DMX_BREAK_BITS = 23;
    localparam int DMX_MAB_BITS = 3;
    localparam int DMX_NUM_SLOTS = 512;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BREAK = 2'd1,
        S_MAB   = 2'd2,
        S_SLOT  = 2'd3
    } dmx_state_e;

endpackage

// File: rtl/dmx512_transmitter_if.sv
// Host-side bundle: channel writes, enable and line outputs.
interface dmx512_transmitter_if;

    logic       tx_enable;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       dmx_tx;
    logic       dmx_oe;
    logic       busy;
    logic       frame_start;

    modport master (
        output tx_enable, wr_en, wr_addr, wr_data,
        input  dmx_tx, dmx_oe, busy, frame_start
    );

    modport slave (
        input  tx_enable, wr_en, wr_addr, wr_data,
        output dmx_tx, dmx_oe, busy, frame_start
    );

endinterface

// File: rtl/dmx_slot_buffer.sv
// Channel value store: one write port, one registered read port.
module dmx_slot_buffer #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_data_q;

    // Read returns the pre-write value on a same-address collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/dmx512_transmitter.sv
// DMX512 frame generator: BREAK, MAB, start code, then the
// channel buffer serialised 8N2, repeating while enabled.
module dmx512_transmitter
    import dmx512_transmitter_pkg::*;
#(
    parameter int CLKS_PER_BIT = DMX_CLKS_PER_BIT,
    parameter int BREAK_BITS   = DMX_BREAK_BITS,
    parameter int MAB_BITS     = DMX_MAB_BITS,
    parameter int NUM_SLOTS    = DMX_NUM_SLOTS
) (
    input  logic clk,
    input  logic reset,
    dmx512_transmitter_if.slave bus
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]    BRK_LAST = 5'(BREAK_BITS - 1);
    localparam logic [4:0]    MAB_LAST = 5'(MAB_BITS - 1);
    localparam logic [9:0]    SLOT_MAX = 10'(NUM_SLOTS);
    localparam logic [3:0]    BIT_LAST = 4'(DMX_SLOT_BITS - 1);

    dmx_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    bcnt_q, bcnt_d;
    logic [9:0]    slot_q, slot_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;
    logic          fs_q, fs_d;

    logic          tick;
    logic          wr_ok;
    logic [9:0]    wr_idx;
    logic [AW-1:0] rd_idx;
    logic [7:0]    rd_data;

    assign tick   = (timer_q == T_LAST);
    assign wr_ok  = bus.wr_en && (bus.wr_addr != 10'd0)
                    && (bus.wr_addr <= SLOT_MAX);
    assign wr_idx = bus.wr_addr - 10'd1;

    // Address tracks the current slot, so the next channel's byte
    // is read on the final cycle of the preceding slot.
    assign rd_idx = (slot_q < SLOT_MAX) ? slot_q[AW-1:0] : '0;

    dmx_slot_buffer #(
        .DEPTH (NUM_SLOTS),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_idx[AW-1:0]),
        .wr_data (bus.wr_data),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bcnt_d  = bcnt_q;
        slot_d  = slot_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        fs_d    = 1'b0;

        if (state_q != S_IDLE) begin
            timer_d = tick ? '0 : timer_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (bus.tx_enable) begin
                    state_d = S_BREAK;
                    bcnt_d  = '0;
                    tx_d    = 1'b0;
                    oe_d    = 1'b1;
                    busy_d  = 1'b1;
                    fs_d    = 1'b1;
                end
            end
            S_BREAK: begin
                if (tick) begin
                    if (bcnt_q == BRK_LAST) begin
                        state_d = S_MAB;
                        bcnt_d  = '0;
                        tx_d    = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            S_MAB: begin
                if (tick) begin
                    if (bcnt_q == MAB_LAST) begin
                        state_d = S_SLOT;
                        bcnt_d  = '0;
                        slot_d  = '0;
                        bit_d   = '0;
                        tx_d    = 1'b0;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            S_SLOT: begin
                if (bit_q == 4'd0 && timer_q == '0) begin
                    shift_d = (slot_q == 10'd0) ? DMX_START_CODE
                                                : rd_data;
                end
                if (tick) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (slot_q == SLOT_MAX) begin
                            slot_d = '0;
                            if (bus.tx_enable) begin
                                state_d = S_BREAK;
                                bcnt_d  = '0;
                                tx_d    = 1'b0;
                                fs_d    = 1'b1;
                            end else begin
                                state_d = S_IDLE;
                                tx_d    = 1'b1;
                                oe_d    = 1'b0;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            slot_d = slot_q + 10'd1;
                            tx_d   = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        if (bit_q < 4'd8) begin
                            tx_d    = shift_q[0];
                            shift_d = {1'b0, shift_q[7:1]};
                        end else begin
                            tx_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bcnt_q  <= '0;
            slot_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bcnt_q  <= bcnt_d;
            slot_q  <= slot_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            fs_q    <= fs_d;
        end
    end

    assign bus.dmx_tx      = tx_q;
    assign bus.dmx_oe      = oe_q;
    assign bus.busy        = busy_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_dmx512_transmitter.sv
// Bench for dmx512_transmitter: decodes the serial line and
// checks it against queued expected slot bytes.
module tb_dmx512_transmitter;

    localparam int CPB = 4;
    localparam int BRK = 23;
    localparam int MAB = 3;
    localparam int NS  = 4;
    localparam int FRAME_CYC = (BRK + MAB + 11 * (NS + 1)) * CPB;

    typedef struct {
        logic [9:0]  addr;
        logic [7:0]  data;
        logic        run;
        logic [39:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] sb_q[$];
    vec_t tbl[9];

    dmx512_transmitter_if bif ();

    dmx512_transmitter #(
        .CLKS_PER_BIT (CPB),
        .BREAK_BITS   (BRK),
        .MAB_BITS     (MAB),
        .NUM_SLOTS    (NS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        bif.wr_en   = 1'b1;
        bif.wr_addr = a;
        bif.wr_data = d;
        @(negedge clk);
        bif.wr_en = 1'b0;
    endtask

    task automatic run_frame(input logic [39:0] exp, input int inj_slot,
                             input logic [7:0] inj_data,
                             input int drop_slot, output int start_cyc);
        int n;
        logic v0, vm, v3, ok;
        logic [7:0] b, e;
        for (int s = 0; s <= NS; s++) sb_q.push_back(exp[39-8*s -: 8]);
        n = 0;
        while (bif.frame_start !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        start_cyc = cyc;
        if (n >= 2000) begin
            chk("frame_start_timeout", 0, 1);
            sb_q.delete();
            return;
        end
        chk("break_entry", {bif.dmx_tx, bif.dmx_oe, bif.busy}, 3'b011);
        n = 0;
        while (bif.dmx_tx === 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("break_len", n, BRK * CPB);
        n = 0;
        while (bif.dmx_tx === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mab_len", n, MAB * CPB);
        for (int s = 0; s <= NS; s++) begin
            if (s == inj_slot) begin
                bif.wr_en   = 1'b1;
                bif.wr_addr = 10'(s);
                bif.wr_data = inj_data;
            end
            if (s == drop_slot) bif.tx_enable = 1'b0;
            ok = 1'b1;
            b  = '0;
            for (int k = 0; k < 11; k++) begin
                v0 = bif.dmx_tx;
                @(negedge clk);
                bif.wr_en = 1'b0;
                @(negedge clk);
                vm = bif.dmx_tx;
                @(negedge clk);
                v3 = bif.dmx_tx;
                @(negedge clk);
                if (v0 !== vm || v3 !== vm) ok = 1'b0;
                if (k == 0 && vm !== 1'b0) ok = 1'b0;
                if (k >= 9 && vm !== 1'b1) ok = 1'b0;
                if (k >= 1 && k <= 8) b[k-1] = vm;
            end
            chk($sformatf("slot%0d_framing", s), ok, 1);
            if (sb_q.size() == 0) begin
                chk("scoreboard_underflow", 0, 1);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("slot%0d_data", s), b, e);
            end
        end
        if (bif.tx_enable) begin
            chk("back_to_back_fs", bif.frame_start, 1);
        end else begin
            chk("idle_after_frame",
                {bif.dmx_tx, bif.dmx_oe, bif.busy}, 3'b100);
            n = 0;
            repeat (100) begin
                @(negedge clk);
                if (bif.frame_start !== 1'b0) n++;
            end
            chk("no_extra_frame_start", n, 0);
        end
    endtask

    initial begin
        int n, sc1, sc2;
        tbl[0] = '{10'd3, 8'h00, 1'b0, 40'h0};
        tbl[1] = '{10'd4, 8'h00, 1'b0, 40'h0};
        tbl[2] = '{10'd1, 8'hA5, 1'b0, 40'h0};
        tbl[3] = '{10'd2, 8'h3C, 1'b1, 40'h00_A5_3C_00_00};
        tbl[4] = '{10'd0, 8'h77, 1'b1, 40'h00_A5_3C_00_00};
        tbl[5] = '{10'd5, 8'h77, 1'b1, 40'h00_A5_3C_00_00};
        tbl[6] = '{10'd4, 8'h81, 1'b0, 40'h0};
        tbl[7] = '{10'd3, 8'h5A, 1'b1, 40'h00_A5_3C_5A_81};
        tbl[8] = '{10'd3, 8'h00, 1'b0, 40'h0};

        bif.tx_enable = 1'b0;
        bif.wr_en     = 1'b0;
        bif.wr_addr   = '0;
        bif.wr_data   = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bif.dmx_tx, bif.dmx_oe, bif.busy,
                              bif.frame_start}, 4'b1000);
        reset = 1'b0;
        n = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bif.dmx_tx !== 1'b1 || bif.dmx_oe !== 1'b0 ||
                bif.busy !== 1'b0 || bif.frame_start !== 1'b0) n++;
        end
        chk("idle_1000_cycles", n, 0);

        for (int i = 0; i < 9; i++) begin
            wr(tbl[i].addr, tbl[i].data);
            if (tbl[i].run) begin
                bif.tx_enable = 1'b1;
                run_frame(tbl[i].exp, -1, 8'h00, 2, sc1);
            end
        end

        bif.tx_enable = 1'b1;
        run_frame(40'h00_A5_3C_00_81, 3, 8'hFF, -1, sc1);
        run_frame(40'h00_A5_3C_FF_81, -1, 8'h00, 0, sc2);
        chk("frame_period", sc2 - sc1, FRAME_CYC);

        bif.tx_enable = 1'b1;
        n = 0;
        while (bif.frame_start !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reset_test_fs_seen", n < 2000, 1);
        repeat ((BRK + MAB + 11) * CPB + 4 * CPB + 1) @(negedge clk);
        chk("slot1_d3_before_reset", bif.dmx_tx, 0);
        reset = 1'b1;
        #1;
        chk("mid_slot_reset", {bif.dmx_tx, bif.busy, bif.dmx_oe}, 3'b100);
        @(negedge clk);
        reset = 1'b0;
        run_frame(40'h00_A5_3C_FF_81, -1, 8'h00, 0, sc1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
